// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for the div block.
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DIV_N = 4;
  function automatic int cntw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int DIV_CW = cntw(DIV_N);
endpackage

// File: rtl/div_cs.sv
// div_cs: one restoring step, subtracts the divisor from the trial remainder when it fits.
module div_cs #(parameter int N = 4) (
  input  logic [N:0]   trial,
  input  logic [N-1:0] d,
  output logic [N-1:0] rem,
  output logic         q
);
  logic [N-1:0] diff;
  // trial - d < d whenever it is taken, so the low N bits are exact
  assign diff = trial[N-1:0] - d;
  assign q = trial >= {1'b0, d};
  assign rem = q ? diff : trial[N-1:0];
endmodule

// File: rtl/div.sv
// div: sequential restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// DIV_OVF_CHECK_EN adds an up-front overflow comparator that short-circuits straight to DONE.
module div import div_pkg::*; #(parameter int N = DIV_N) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] P,
  input  logic [N-1:0]   B,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           busy,
  output logic           done,
  output logic           ovf
);
  localparam int CW = cntw(N);
  state_t st;
  logic [N-1:0] rem, sr, dv, nr;
  logic [CW-1:0] cnt;
  logic q, acc, ov;
  assign acc = start && st != RUN;
  assign busy = st == RUN;
  assign done = st == DONE;
`ifdef DIV_OVF_CHECK_EN
  assign ov = P[2*N-1:N] >= B;
`else
  assign ov = 1'b0;
`endif
  div_cs #(.N(N)) u_cs (.trial({rem, sr[N-1]}), .d(dv), .rem(nr), .q(q));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      rem <= '0;
      sr <= '0;
      dv <= '0;
      cnt <= '0;
      Q <= '0;
      R <= '0;
      ovf <= 1'b0;
    end else if (acc) begin
      rem <= P[2*N-1:N];
      sr <= P[N-1:0];
      dv <= B;
      cnt <= CW'(N - 1);
      st <= ov ? DONE : RUN;
      if (ov) begin
        Q <= '1;
        R <= '0;
        ovf <= 1'b1;
      end
    end else if (st == RUN) begin
      rem <= nr;
      sr <= {sr[N-2:0], q};
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        st <= DONE;
        Q <= {sr[N-2:0], q};
        R <= nr;
        ovf <= 1'b0;
      end
    end else if (st == DONE)
      st <= IDLE;
endmodule

// File: tb/tb_div.sv
// tb_div: directed checks of the div block at N=4, with and without DIV_OVF_CHECK_EN.
module tb_div;
  logic clk = 0, rst_n = 0, start = 0;
  logic [7:0] P = 0;
  logic [3:0] B = 0;
  logic [3:0] Q, R;
  logic busy, done, ovf;
  int total = 0, bad = 0;
  int lat, bc;

  div #(.N(4)) dut (.clk(clk), .rst_n(rst_n), .start(start), .P(P), .B(B),
                    .Q(Q), .R(R), .busy(busy), .done(done), .ovf(ovf));

  always #5 clk = ~clk;

  // lat counts edges after the accepting edge until done is seen; bc counts busy cycles
  task automatic run_div(input logic [7:0] p, input logic [3:0] b);
    @(negedge clk);
    start = 1; P = p; B = b;
    @(negedge clk);
    start = 0; P = 8'($urandom); B = 4'($urandom);
    lat = 0; bc = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    #12;
    total++;
    if ({Q, R, busy, done, ovf} !== 11'd0) begin
      bad++;
      $display("FAIL reset_state: got Q=%h R=%h busy=%b done=%b ovf=%b, want all 0", Q, R, busy, done, ovf);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_release: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    run_div(8'd143, 4'd11);
    total++;
    if (Q !== 4'd13 || R !== 4'd0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL basic_143_11: got Q=%0d R=%0d ovf=%b, want 13 0 0", Q, R, ovf);
    end
    total++;
    if (lat !== 4 || bc !== 4) begin
      bad++;
      $display("FAIL basic_timing: got latency=%0d busy_cycles=%0d, want 4 4", lat, bc);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_in_done: got %b, want 0", busy);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (Q !== 4'd13 || R !== 4'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL hold_after_done: got Q=%0d R=%0d done=%b, want 13 0 0", Q, R, done);
    end
    run_div(8'd100, 4'd7);
    total++;
    if (Q !== 4'd14 || R !== 4'd2 || ovf !== 1'b0 || lat !== 4) begin
      bad++;
      $display("FAIL basic_100_7: got Q=%0d R=%0d ovf=%b lat=%0d, want 14 2 0 4", Q, R, ovf, lat);
    end
  endtask

  task automatic test_ovf;
`ifdef DIV_OVF_CHECK_EN
    run_div(8'h12, 4'd0);
    total++;
    if (ovf !== 1'b1 || Q !== 4'hF || R !== 4'd0 || lat !== 0 || bc !== 0) begin
      bad++;
      $display("FAIL ovf_div0: got ovf=%b Q=%h R=%h lat=%0d busy=%0d, want 1 f 0 0 0", ovf, Q, R, lat, bc);
    end
    run_div(8'hA0, 4'd9);
    total++;
    if (ovf !== 1'b1 || Q !== 4'hF || R !== 4'd0 || lat !== 0) begin
      bad++;
      $display("FAIL ovf_a0_9: got ovf=%b Q=%h R=%h lat=%0d, want 1 f 0 0", ovf, Q, R, lat);
    end
    run_div(8'd45, 4'd6);
    total++;
    if (ovf !== 1'b0 || Q !== 4'd7 || R !== 4'd3) begin
      bad++;
      $display("FAIL ovf_clear: got ovf=%b Q=%0d R=%0d, want 0 7 3", ovf, Q, R);
    end
`else
    run_div(8'h12, 4'd0);
    total++;
    if (ovf !== 1'b0 || lat !== 4) begin
      bad++;
      $display("FAIL noovf_div0: got ovf=%b lat=%0d, want 0 4", ovf, lat);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int k = 0;
    @(negedge clk);
    start = 1; P = 8'd143; B = 4'd11;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (done !== 1'b1 || Q !== 4'd13 || R !== 4'd0) begin
      bad++;
      $display("FAIL b2b_first: got done=%b Q=%0d R=%0d, want 1 13 0", done, Q, R);
    end
    P = 8'd45; B = 4'd6;
    @(negedge clk);
    start = 0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
    end
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (Q !== 4'd7 || R !== 4'd3 || lat !== 4) begin
      bad++;
      $display("FAIL b2b_second: got Q=%0d R=%0d lat=%0d, want 7 3 4", Q, R, lat);
    end
  endtask

  task automatic test_ignore;
    int extra = 0;
    @(negedge clk);
    start = 1; P = 8'd100; B = 4'd7;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1; P = 8'h12; B = 4'd3;
    @(negedge clk);
    start = 0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (Q !== 4'd14 || R !== 4'd2 || lat !== 2) begin
      bad++;
      $display("FAIL ignore_result: got Q=%0d R=%0d lat=%0d, want 14 2 2", Q, R, lat);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    total++;
    if (extra !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_extra_done: got dones=%0d busy=%b, want 0 0", extra, busy);
    end
  endtask

  task automatic test_abort;
    int seen = 0;
    @(negedge clk);
    start = 1; P = 8'd100; B = 4'd7;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    total++;
    if ({Q, R, busy, done, ovf} !== 11'd0) begin
      bad++;
      $display("FAIL abort_state: got Q=%h R=%h busy=%b done=%b ovf=%b, want all 0", Q, R, busy, done, ovf);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d busy/done cycles, want 0", seen);
    end
    run_div(8'd255, 4'd15);
`ifdef DIV_OVF_CHECK_EN
    total++;
    if (ovf !== 1'b1 || Q !== 4'hF || R !== 4'd0 || lat !== 0) begin
      bad++;
      $display("FAIL abort_then_ovf: got ovf=%b Q=%h R=%h lat=%0d, want 1 f 0 0", ovf, Q, R, lat);
    end
`else
    total++;
    if (ovf !== 1'b0 || lat !== 4) begin
      bad++;
      $display("FAIL abort_then_div: got ovf=%b lat=%0d, want 0 4", ovf, lat);
    end
`endif
  endtask

  task automatic test_roundtrip;
    logic [7:0] p;
    for (int a = 1; a < 16; a++)
      for (int b = 1; b < 16; b++)
        for (int r = 0; r < b; r++) begin
          p = 8'(a * b + r);
          run_div(p, 4'(b));
          total++;
          if (Q !== 4'(a) || R !== 4'(r) || ovf !== 1'b0 || lat !== 4) begin
            bad++;
            $display("FAIL roundtrip P=%0d B=%0d: got Q=%0d R=%0d ovf=%b lat=%0d, want %0d %0d 0 4",
                     p, b, Q, R, ovf, lat, a, r);
          end
        end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ovf;
    test_back_to_back;
    test_ignore;
    test_abort;
    test_roundtrip;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
